// File: rtl/trigger_pkg.sv
// rtl/trigger_pkg.sv - shared state and mode encodings for level_trigger
//
// Purpose : FSM state encoding (o_Level is state bit 1) and pulse-mode constants.
// Ports   : none (package)

package trigger_pkg;

   typedef enum logic [1:0] {
      S_LOW  = 2'b00,
      S_RISE = 2'b01,
      S_HIGH = 2'b10,
      S_FALL = 2'b11
   } state_t;

   localparam logic [1:0] MODE_NONE = 2'd0;
   localparam logic [1:0] MODE_RISE = 2'd1;
   localparam logic [1:0] MODE_FALL = 2'd2;
   localparam logic [1:0] MODE_BOTH = 2'd3;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with clear-wins rule
//
// Purpose : counts inc strobes, holds at all-ones, clr forces zero even when inc is set.
// Ports   : i_CLK   clock, rising edge
//           i_RST   synchronous active-high reset
//           inc     count one event this cycle
//           clr     clear count (dominates inc)
//           count   current count, EVW bits

module sat_counter #(
   parameter int EVW = 8
) (
   input  logic           i_CLK,
   input  logic           i_RST,
   input  logic           inc,
   input  logic           clr,
   output logic [EVW-1:0] count
);

   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != {EVW{1'b1}})) begin
         count <= count + EVW'(1);
      end
   end

endmodule

// File: rtl/level_trigger.sv
// rtl/level_trigger.sv - hysteretic, debounced threshold trigger with event pulse and counter
//
// Purpose : qualifies a W-bit level stream against a rise threshold (i_ThHi) and a fall
//           threshold (i_ThLo); DEB consecutive qualifying valid samples are needed to
//           change the level. Each change is a rise or fall event; events selected by
//           i_Mode produce a one-cycle o_Pulse and are counted in o_Events.
// Ports   : i_CLK     clock, rising edge
//           i_RST     synchronous active-high reset
//           i_Valid   i_Lv carries a sample this cycle
//           i_Lv      sampled level (unsigned)
//           i_ThHi    rise threshold, qualifies when i_Lv > i_ThHi
//           i_ThLo    fall threshold, qualifies when i_Lv < i_ThLo
//           i_Mode    pulse mode: 0 none, 1 rise, 2 fall, 3 both
//           i_Clr     clear event counter
//           o_Level   debounced level
//           o_Pulse   one-cycle event pulse
//           o_Events  saturating count of emitted pulses

module level_trigger
   import trigger_pkg::*;
#(
   parameter int W   = 12,
   parameter int DEB = 4,
   parameter int EVW = 8
) (
   input  logic           i_CLK,
   input  logic           i_RST,
   input  logic           i_Valid,
   input  logic [W-1:0]   i_Lv,
   input  logic [W-1:0]   i_ThHi,
   input  logic [W-1:0]   i_ThLo,
   input  logic [1:0]     i_Mode,
   input  logic           i_Clr,
   output logic           o_Level,
   output logic           o_Pulse,
   output logic [EVW-1:0] o_Events
);

   localparam int CW = $clog2(DEB + 1);

   state_t        state_q, state_n;
   logic [CW-1:0] cnt_q, cnt_n;
   logic          pulse_q, pulse_n;
   logic          above, below;
   logic          fire_rise, fire_fall;
   logic          last_needed;

   assign above       = (i_Lv > i_ThHi);
   assign below       = (i_Lv < i_ThLo);
   // Current sample would be the DEB-th qualifying one in a RISE/FALL run.
   assign last_needed = ((int'(cnt_q) + 1) == DEB);

   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         state_q <= S_LOW;
         cnt_q   <= '0;
         pulse_q <= 1'b0;
      end else begin
         state_q <= state_n;
         cnt_q   <= cnt_n;
         pulse_q <= pulse_n;
      end
   end

   always_comb begin
      state_n   = state_q;
      cnt_n     = cnt_q;
      fire_rise = 1'b0;
      fire_fall = 1'b0;
      if (i_Valid) begin
         case (state_q)
            S_LOW: begin
               if (above) begin
                  if (DEB == 1) begin
                     state_n   = S_HIGH;
                     fire_rise = 1'b1;
                  end else begin
                     state_n = S_RISE;
                     cnt_n   = CW'(1);
                  end
               end
            end
            S_RISE: begin
               if (above) begin
                  if (last_needed) begin
                     state_n   = S_HIGH;
                     cnt_n     = '0;
                     fire_rise = 1'b1;
                  end else begin
                     cnt_n = cnt_q + CW'(1);
                  end
               end else begin
                  state_n = S_LOW;
                  cnt_n   = '0;
               end
            end
            S_HIGH: begin
               if (below) begin
                  if (DEB == 1) begin
                     state_n   = S_LOW;
                     fire_fall = 1'b1;
                  end else begin
                     state_n = S_FALL;
                     cnt_n   = CW'(1);
                  end
               end
            end
            S_FALL: begin
               if (below) begin
                  if (last_needed) begin
                     state_n   = S_LOW;
                     cnt_n     = '0;
                     fire_fall = 1'b1;
                  end else begin
                     cnt_n = cnt_q + CW'(1);
                  end
               end else begin
                  state_n = S_HIGH;
                  cnt_n   = '0;
               end
            end
            default: begin
               state_n = S_LOW;
               cnt_n   = '0;
            end
         endcase
      end
   end

   // Mode is sampled on the firing cycle, so a mode change only affects later events.
   always_comb begin
      pulse_n = (fire_rise && ((i_Mode == MODE_RISE) || (i_Mode == MODE_BOTH))) ||
                (fire_fall && ((i_Mode == MODE_FALL) || (i_Mode == MODE_BOTH)));
   end

   assign o_Level = state_q[1];
   assign o_Pulse = pulse_q;

   // Counter increments on the same edge that registers o_Pulse.
   sat_counter #(
      .EVW (EVW)
   ) u_events (
      .i_CLK (i_CLK),
      .i_RST (i_RST),
      .inc   (pulse_n),
      .clr   (i_Clr),
      .count (o_Events)
   );

endmodule

// File: tb/tb_level_trigger.sv
// tb/tb_level_trigger.sv - randomized self-checking bench for level_trigger against a run-length model

module tb_level_trigger;

   localparam int W    = 12;
   localparam int EVW0 = 2;
   localparam int EVW1 = 8;

   logic            i_CLK = 1'b0;
   logic            i_RST = 1'b1;
   logic            i_Valid = 1'b0;
   logic [W-1:0]    i_Lv = '0;
   logic [W-1:0]    i_ThHi = 12'd2000;
   logic [W-1:0]    i_ThLo = 12'd1800;
   logic [1:0]      i_Mode = 2'd1;
   logic            i_Clr = 1'b0;

   logic            lvl0, pls0, lvl1, pls1;
   logic [EVW0-1:0] ev0;
   logic [EVW1-1:0] ev1;

   int n_vec = 0;
   int n_err = 0;

   // model state per instance: [0] DEB=3 EVW=2, [1] DEB=1 EVW=8
   int m_deb [2] = '{3, 1};
   int m_max [2] = '{3, 255};
   int m_lvl [2];
   int m_run [2];
   int m_pls [2];
   int m_ev  [2];

   always #5 i_CLK = ~i_CLK;

   level_trigger #(.W(W), .DEB(3), .EVW(EVW0)) u_dut0 (
      .i_CLK (i_CLK), .i_RST (i_RST), .i_Valid (i_Valid), .i_Lv (i_Lv),
      .i_ThHi (i_ThHi), .i_ThLo (i_ThLo), .i_Mode (i_Mode), .i_Clr (i_Clr),
      .o_Level (lvl0), .o_Pulse (pls0), .o_Events (ev0)
   );

   level_trigger #(.W(W), .DEB(1), .EVW(EVW1)) u_dut1 (
      .i_CLK (i_CLK), .i_RST (i_RST), .i_Valid (i_Valid), .i_Lv (i_Lv),
      .i_ThHi (i_ThHi), .i_ThLo (i_ThLo), .i_Mode (i_Mode), .i_Clr (i_Clr),
      .o_Level (lvl1), .o_Pulse (pls1), .o_Events (ev1)
   );

   task automatic check_eq(input string tag, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Level model: count consecutive qualifying valid samples; flip after DEB of them.
   task automatic model_edge(input int k);
      bit q;
      if (i_RST) begin
         m_lvl[k] = 0; m_run[k] = 0; m_pls[k] = 0; m_ev[k] = 0;
      end else begin
         m_pls[k] = 0;
         if (i_Valid) begin
            q = (m_lvl[k] != 0) ? (i_Lv < i_ThLo) : (i_Lv > i_ThHi);
            if (q) begin
               m_run[k] = m_run[k] + 1;
               if (m_run[k] == m_deb[k]) begin
                  m_lvl[k] = 1 - m_lvl[k];
                  m_run[k] = 0;
                  m_pls[k] = (m_lvl[k] != 0) ? int'(i_Mode[0]) : int'(i_Mode[1]);
               end
            end else begin
               m_run[k] = 0;
            end
         end
         if (i_Clr) m_ev[k] = 0;
         else if (m_pls[k] != 0 && m_ev[k] < m_max[k]) m_ev[k] = m_ev[k] + 1;
      end
   endtask

   task automatic step(input bit v, input int lv, input bit clr, input bit rst);
      i_Valid = v;
      i_Lv    = W'(lv);
      i_Clr   = clr;
      i_RST   = rst;
      @(posedge i_CLK);
      model_edge(0);
      model_edge(1);
      #1;
      check_eq("level_deb3",  int'(lvl0), m_lvl[0]);
      check_eq("pulse_deb3",  int'(pls0), m_pls[0]);
      check_eq("events_deb3", int'(ev0),  m_ev[0]);
      check_eq("level_deb1",  int'(lvl1), m_lvl[1]);
      check_eq("pulse_deb1",  int'(pls1), m_pls[1]);
      check_eq("events_deb1", int'(ev1),  m_ev[1]);
   endtask

   task automatic samples(input int lv, input int n);
      for (int i = 0; i < n; i++) step(1'b1, lv, 1'b0, 1'b0);
   endtask

   initial begin
      // reset state
      step(1'b0, 0, 1'b0, 1'b1);
      step(1'b0, 0, 1'b0, 1'b1);

      // rise
      i_Mode = 2'd1;
      samples(2100, 3);
      step(1'b0, 0, 1'b0, 1'b0);

      // broken debounce
      step(1'b0, 0, 1'b0, 1'b1);
      samples(2100, 2);
      samples(1900, 1);
      samples(2100, 3);
      step(1'b0, 0, 1'b0, 1'b0);

      // hysteresis band, fall silent in mode 1, fall pulsing in mode 2
      samples(1900, 20);
      samples(1700, 3);
      samples(2100, 3);
      i_Mode = 2'd2;
      samples(1700, 3);
      step(1'b0, 0, 1'b0, 1'b0);

      // valid gaps
      i_Mode = 2'd1;
      samples(2100, 1);
      for (int i = 0; i < 5; i++) step(1'b0, 0, 1'b0, 1'b0);
      samples(2100, 2);
      samples(1700, 3);

      // saturation, then clear coinciding with a pulse
      i_Mode = 2'd3;
      for (int i = 0; i < 5; i++) begin
         samples(2100, 3);
         samples(1700, 3);
      end
      samples(2100, 2);
      step(1'b1, 2100, 1'b1, 1'b0);
      step(1'b0, 0, 1'b0, 1'b0);
      samples(1700, 3);

      // reset mid-debounce
      samples(2100, 2);
      step(1'b0, 0, 1'b0, 1'b1);
      samples(2100, 2);
      samples(2100, 1);
      step(1'b0, 0, 1'b0, 1'b0);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         if ((n % 250) == 0) begin
            if ($urandom_range(0, 3) == 0) begin
               i_ThHi = W'($urandom_range(0, 4095));
               i_ThLo = W'($urandom_range(0, 4095));
            end else begin
               i_ThHi = 12'd2000;
               i_ThLo = 12'd1800;
            end
         end
         if ($urandom_range(0, 15) == 0) i_Mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0)
            step(1'b1, int'($urandom_range(0, 4095)), ($urandom_range(0, 40) == 0),
                 ($urandom_range(0, 200) == 0));
         else
            step(($urandom_range(0, 4) != 0), int'($urandom_range(1600, 2200)),
                 ($urandom_range(0, 40) == 0), ($urandom_range(0, 200) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
